qsfp_mgmt_ctrl: RTL

- Sideband management sequencer for one QSFP28 cage feeding the 100G Ethernet subsystem.
- Detects module insertion and removal, then runs the power-up sequence: refclk reset, module reset pulse, init wait.
- Drives the QSFP low-speed control pins and reports readiness and interrupts to the Ethernet core and to software status.
- Sits beside the Ethernet instance in the board wrapper, in the Ethernet init clock domain.

---
 rtl/qsfp_mgmt_pkg.sv | 26 ++
 rtl/qsfp_debounce.sv | 58 +++++
 rtl/qsfp_mgmt_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/qsfp_mgmt_pkg.sv
// qsfp_mgmt_pkg: shared types and constants for the QSFP28 management sequencer
// Holds the FSM state encoding, the default refclk frequency select and the
// helper that sizes the shared sequencing timer.
package qsfp_mgmt_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_ABSENT     = 3'd0,
        ST_REFCLK_RST = 3'd1,
        ST_MOD_RST    = 3'd2,
        ST_MOD_INIT   = 3'd3,
        ST_READY      = 3'd4
    } state_e;

    localparam logic [1:0] FS_DEFAULT_ENC = 2'b01;

    // One extra bit over the largest timed interval keeps PARAM-1 representable
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/qsfp_debounce.sv
// qsfp_debounce: 2-FF synchroniser plus optional stability filter for an async pin
// Ports: clock, reset (sync, active-high), async_in (raw pin), db_out (filtered level).
// Macro QSFP_MGMT_DEBOUNCE_EN: when defined, db_out only follows the synchronised
// level after it has differed for DEBOUNCE_CYCLES consecutive cycles; when
// undefined, db_out is the synchronised level directly.
module qsfp_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic db_out
);

    logic [1:0] sync_q, sync_d;

    assign sync_d = {sync_q[0], async_in};

    always_ff @(posedge clock) begin
        if (reset) sync_q <= 2'b11;
        else sync_q <= sync_d;
    end

`ifdef QSFP_MGMT_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic db_q, db_d;

    // Any cycle where the synchronised level agrees with db_q restarts the count
    always_comb begin
        db_d = db_q;
        cnt_d = '0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = sync_q[1];
            else cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            db_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            db_q <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign db_out = db_q;
`else
    logic unused_cfg;

    assign unused_cfg = (DEBOUNCE_CYCLES > 0);
    assign db_out = sync_q[1];
`endif

endmodule

// File: rtl/qsfp_mgmt_ctrl.sv
// qsfp_mgmt_ctrl: QSFP28 cage insertion detect and power-up sequencer
// Inputs : clock, reset (sync, active-high), enable, restart, lpmode_req, fs_sel[1:0],
//          int_clear, qsfp_modprsl, qsfp_intl (both async, active-low).
// Outputs: qsfp_resetl, qsfp_lpmode, qsfp_modsell, qsfp_refclk_reset, qsfp_fs[1:0],
//          mod_present, link_ready, int_pending, int_count[7:0], state[2:0].
// Macro QSFP_MGMT_DEBOUNCE_EN enables the presence debounce filter.
module qsfp_mgmt_ctrl
    import qsfp_mgmt_pkg::*;
#(
    parameter int         REFCLK_RST_CYCLES = 1000,
    parameter int         RESET_CYCLES      = 1000,
    parameter int         INIT_CYCLES       = 20000000,
    parameter int         DEBOUNCE_CYCLES   = 1024,
    parameter logic [1:0] FS_DEFAULT        = FS_DEFAULT_ENC
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         restart,
    input  logic         lpmode_req,
    input  logic [1:0]   fs_sel,
    input  logic         int_clear,
    input  logic         qsfp_modprsl,
    input  logic         qsfp_intl,
    output logic         qsfp_resetl,
    output logic         qsfp_lpmode,
    output logic         qsfp_modsell,
    output logic         qsfp_refclk_reset,
    output logic [1:0]   qsfp_fs,
    output logic         mod_present,
    output logic         link_ready,
    output logic         int_pending,
    output logic [7:0]   int_count,
    output logic [STATE_W-1:0] state
);

    localparam int TW = timer_width(REFCLK_RST_CYCLES, RESET_CYCLES, INIT_CYCLES);

    state_e state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0] fs_q, fs_d;
    logic resetl_q, resetl_d, lpmode_q, lpmode_d, modsell_q, modsell_d;
    logic refclk_reset_q, refclk_reset_d, link_ready_q, link_ready_d;
    logic [1:0] intl_sync_q, intl_sync_d;
    logic intl_prev_q, intl_prev_d;
    logic int_pending_q, int_pending_d;
    logic [7:0] int_count_q, int_count_d;
    logic prs_db, present, enter, int_hit;

    qsfp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prs_db (
        .clock    (clock),
        .reset    (reset),
        .async_in (qsfp_modprsl),
        .db_out   (prs_db)
    );

    assign present = ~prs_db;

    // enter marks every transition into a timed state, including a restart
    // that re-enters REFCLK_RST from itself, so the timer always reloads.
    always_comb begin
        state_d = state_q;
        enter = 1'b0;
        if (!present || !enable) begin
            state_d = ST_ABSENT;
        end else if (restart && state_q != ST_ABSENT) begin
            state_d = ST_REFCLK_RST;
            enter = 1'b1;
        end else begin
            case (state_q)
                ST_ABSENT: begin
                    state_d = ST_REFCLK_RST;
                    enter = 1'b1;
                end
                ST_REFCLK_RST: if (tmr_q == '0) begin
                    state_d = ST_MOD_RST;
                    enter = 1'b1;
                end
                ST_MOD_RST: if (tmr_q == '0) begin
                    state_d = ST_MOD_INIT;
                    enter = 1'b1;
                end
                ST_MOD_INIT: if (tmr_q == '0) state_d = ST_READY;
                default: state_d = state_q;
            endcase
        end
        tmr_d = !enter ? ((tmr_q == '0) ? '0 : tmr_q - 1'b1) :
                (state_d == ST_REFCLK_RST) ? TW'(REFCLK_RST_CYCLES - 1) :
                (state_d == ST_MOD_RST) ? TW'(RESET_CYCLES - 1) : TW'(INIT_CYCLES - 1);
    end

    // Pin outputs are decoded from the next state so they change together with state
    always_comb begin
        resetl_d = (state_d == ST_MOD_INIT) || (state_d == ST_READY);
        lpmode_d = (state_d == ST_READY) ? lpmode_req : 1'b1;
        modsell_d = (state_d != ST_READY);
        refclk_reset_d = (state_d == ST_ABSENT) || (state_d == ST_REFCLK_RST);
        link_ready_d = (state_d == ST_READY);
        fs_d = (enter && state_d == ST_REFCLK_RST) ? fs_sel : fs_q;
    end

    // A fresh edge beats a simultaneous clear so no interrupt is lost
    always_comb begin
        intl_sync_d = {intl_sync_q[0], qsfp_intl};
        intl_prev_d = intl_sync_q[1];
        int_hit = intl_prev_q && !intl_sync_q[1] && (state_q == ST_READY);
        int_pending_d = int_hit || (int_pending_q && !int_clear);
        int_count_d = (state_d == ST_ABSENT && state_q != ST_ABSENT) ? 8'd0 :
                      (int_hit && int_count_q != 8'hFF) ? int_count_q + 8'd1 : int_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_ABSENT;
            tmr_q <= '0;
            fs_q <= FS_DEFAULT;
            resetl_q <= 1'b0;
            lpmode_q <= 1'b1;
            modsell_q <= 1'b1;
            refclk_reset_q <= 1'b1;
            link_ready_q <= 1'b0;
            intl_sync_q <= 2'b11;
            intl_prev_q <= 1'b1;
            int_pending_q <= 1'b0;
            int_count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            tmr_q <= tmr_d;
            fs_q <= fs_d;
            resetl_q <= resetl_d;
            lpmode_q <= lpmode_d;
            modsell_q <= modsell_d;
            refclk_reset_q <= refclk_reset_d;
            link_ready_q <= link_ready_d;
            intl_sync_q <= intl_sync_d;
            intl_prev_q <= intl_prev_d;
            int_pending_q <= int_pending_d;
            int_count_q <= int_count_d;
        end
    end

    assign qsfp_resetl = resetl_q;
    assign qsfp_lpmode = lpmode_q;
    assign qsfp_modsell = modsell_q;
    assign qsfp_refclk_reset = refclk_reset_q;
    assign qsfp_fs = fs_q;
    assign mod_present = present;
    assign link_ready = link_ready_q;
    assign int_pending = int_pending_q;
    assign int_count = int_count_q;
    assign state = state_q;

endmodule
